gcd_command_parser: RTL and testbench



---
 rtl/gcd_command_parser.sv | 179 +++++++++++++++++
 tb/tb_gcd_command_parser.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_command_parser.sv
// Frames UART bytes (header, A, B, XOR checksum) into two 16-bit GCD operands,
// validates them, and hands each good command to the engine with a start pulse.
module gcd_command_parser #(
    parameter logic [7:0] HEADER_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter int         CNT_WIDTH      = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    input  logic        i_engine_busy,
    output logic [15:0] o_gcd1,
    output logic [15:0] o_gcd2,
    output logic        o_start_gcd,
    output logic        o_frame_error,
    output logic [1:0]  o_error_code,
    output logic [7:0]  o_accepted_count,
    output logic        o_parser_idle
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_A_HI    = 3'd1;
    localparam logic [2:0] S_A_LO    = 3'd2;
    localparam logic [2:0] S_B_HI    = 3'd3;
    localparam logic [2:0] S_B_LO    = 3'd4;
    localparam logic [2:0] S_CHK     = 3'd5;
    localparam logic [2:0] S_CHECK   = 3'd6;
    localparam logic [2:0] S_PENDING = 3'd7;

    localparam logic [1:0] E_OVERRUN  = 2'd0;
    localparam logic [1:0] E_CHECKSUM = 2'd1;
    localparam logic [1:0] E_ZERO     = 2'd2;
    localparam logic [1:0] E_TIMEOUT  = 2'd3;

    // The silent cycle that would bring the counter to TIMEOUT_CYCLES-1 aborts the frame.
    localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 2);

    logic [2:0]           r_state;
    logic [15:0]          r_opA;
    logic [15:0]          r_opB;
    logic [7:0]           r_xor;
    logic [7:0]           r_chk;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [15:0]          r_gcd1;
    logic [15:0]          r_gcd2;
    logic                 r_start;
    logic                 r_err;
    logic [1:0]           r_code;
    logic [7:0]           r_count;
    logic                 r_idle;

    logic [2:0] w_next;
    logic       w_inFrame;
    logic       w_accept;
    logic       w_timeout;
    logic       w_issue;
    logic       w_err;
    logic [1:0] w_code;

    assign w_inFrame = (r_state >= S_A_HI) && (r_state <= S_CHK);

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_timeout = 1'b0;
        w_issue   = 1'b0;
        w_err     = 1'b0;
        w_code    = E_OVERRUN;
        case (r_state)
            S_IDLE: begin
                if (i_rx_valid && (i_rx_data == HEADER_BYTE)) begin
                    w_next = S_A_HI;
                end
            end
            S_A_HI, S_A_LO, S_B_HI, S_B_LO, S_CHK: begin
                if (i_rx_valid) begin
                    w_accept = 1'b1;
                    w_next   = r_state + 3'd1;
                end else if (r_cnt == TMO_LAST) begin
                    w_timeout = 1'b1;
                    w_err     = 1'b1;
                    w_code    = E_TIMEOUT;
                    w_next    = S_IDLE;
                end
            end
            S_CHECK: begin
                // A stray byte is an overrun, but the frame verdict still stands.
                if (i_rx_valid) begin
                    w_err  = 1'b1;
                    w_code = E_OVERRUN;
                end
                if (r_xor != r_chk) begin
                    w_err  = 1'b1;
                    w_code = E_CHECKSUM;
                    w_next = S_IDLE;
                end else if ((r_opA == 16'd0) || (r_opB == 16'd0)) begin
                    w_err  = 1'b1;
                    w_code = E_ZERO;
                    w_next = S_IDLE;
                end else if (i_engine_busy) begin
                    w_next = S_PENDING;
                end else begin
                    w_issue = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            default: begin
                if (i_rx_valid) begin
                    w_err  = 1'b1;
                    w_code = E_OVERRUN;
                end
                if (!i_engine_busy) begin
                    w_issue = 1'b1;
                    w_next  = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_opA   <= '0;
            r_opB   <= '0;
            r_xor   <= '0;
            r_chk   <= '0;
            r_cnt   <= '0;
            r_gcd1  <= '0;
            r_gcd2  <= '0;
            r_start <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= E_OVERRUN;
            r_count <= '0;
            r_idle  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_start <= w_issue;
            r_err   <= w_err;
            r_idle  <= (w_next == S_IDLE);
            if (w_err) begin
                r_code <= w_code;
            end
            if (w_issue) begin
                r_gcd1  <= r_opA;
                r_gcd2  <= r_opB;
                r_count <= r_count + 8'd1;
            end
            if (w_inFrame && !w_accept && !w_timeout) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end else begin
                r_cnt <= '0;
            end
            if (r_state == S_IDLE) begin
                r_xor <= '0;
            end else if (w_accept && (r_state != S_CHK)) begin
                r_xor <= r_xor ^ i_rx_data;
            end
            if (w_accept) begin
                case (r_state)
                    S_A_HI:  r_opA[15:8] <= i_rx_data;
                    S_A_LO:  r_opA[7:0]  <= i_rx_data;
                    S_B_HI:  r_opB[15:8] <= i_rx_data;
                    S_B_LO:  r_opB[7:0]  <= i_rx_data;
                    default: r_chk       <= i_rx_data;
                endcase
            end
        end
    end

    assign o_gcd1           = r_gcd1;
    assign o_gcd2           = r_gcd2;
    assign o_start_gcd      = r_start;
    assign o_frame_error    = r_err;
    assign o_error_code     = r_code;
    assign o_accepted_count = r_count;
    assign o_parser_idle    = r_idle;

endmodule

// File: tb/tb_gcd_command_parser.sv
// Directed bench for gcd_command_parser: framing, error causes, busy hold,
// inter-byte timeout, reset recovery and accepted-count wrap.
module tb_gcd_command_parser;

    logic        clk;
    logic        reset;
    logic        rxValid;
    logic [7:0]  rxData;
    logic        engineBusy;
    logic [15:0] gcd1;
    logic [15:0] gcd2;
    logic        startGcd;
    logic        frameError;
    logic [1:0]  errorCode;
    logic [7:0]  acceptedCount;
    logic        parserIdle;

    int checks = 0;
    int errors = 0;

    gcd_command_parser #(
        .HEADER_BYTE(8'hA5),
        .TIMEOUT_CYCLES(16),
        .CNT_WIDTH(16)
    ) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_rx_valid(rxValid),
        .i_rx_data(rxData),
        .i_engine_busy(engineBusy),
        .o_gcd1(gcd1),
        .o_gcd2(gcd2),
        .o_start_gcd(startGcd),
        .o_frame_error(frameError),
        .o_error_code(errorCode),
        .o_accepted_count(acceptedCount),
        .o_parser_idle(parserIdle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        rxValid = 1'b1;
        rxData  = b;
        tick();
        rxValid = 1'b0;
        rxData  = 8'h00;
    endtask

    task automatic sendFrame(input logic [7:0] b0, b1, b2, b3, b4, b5);
        sendByte(b0);
        sendByte(b1);
        sendByte(b2);
        sendByte(b3);
        sendByte(b4);
        sendByte(b5);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (gcd1 !== 16'h0 || gcd2 !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_operands actual=%h/%h required=0000/0000", gcd1, gcd2);
        end
        checks++;
        if (startGcd !== 1'b0 || frameError !== 1'b0 || errorCode !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_flags actual=%b%b%0d required=000", startGcd, frameError, errorCode);
        end
        checks++;
        if (acceptedCount !== 8'd0 || parserIdle !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_count_idle actual=%0d/%b required=0/1", acceptedCount, parserIdle);
        end
    endtask

    task automatic test_valid_frame();
        sendFrame(8'hA5, 8'h00, 8'h30, 8'h00, 8'h12, 8'h22);
        checks++;
        if (startGcd !== 1'b0 || parserIdle !== 1'b0) begin
            errors++;
            $display("[TB] FAIL valid_n1 actual=start%b idle%b required=start0 idle0", startGcd, parserIdle);
        end
        tick();
        checks++;
        if (startGcd !== 1'b1 || frameError !== 1'b0) begin
            errors++;
            $display("[TB] FAIL valid_start actual=start%b err%b required=start1 err0", startGcd, frameError);
        end
        checks++;
        if (gcd1 !== 16'h0030 || gcd2 !== 16'h0012) begin
            errors++;
            $display("[TB] FAIL valid_operands actual=%h/%h required=0030/0012", gcd1, gcd2);
        end
        checks++;
        if (acceptedCount !== 8'd1 || parserIdle !== 1'b1) begin
            errors++;
            $display("[TB] FAIL valid_count actual=%0d/%b required=1/1", acceptedCount, parserIdle);
        end
        tick();
        checks++;
        if (startGcd !== 1'b0) begin
            errors++;
            $display("[TB] FAIL valid_single_pulse actual=%b required=0", startGcd);
        end
    endtask

    task automatic test_bad_checksum();
        sendFrame(8'hA5, 8'h00, 8'h30, 8'h00, 8'h12, 8'h23);
        tick();
        checks++;
        if (frameError !== 1'b1 || errorCode !== 2'd1 || startGcd !== 1'b0) begin
            errors++;
            $display("[TB] FAIL chk_error actual=err%b code%0d start%b required=err1 code1 start0",
                     frameError, errorCode, startGcd);
        end
        checks++;
        if (gcd1 !== 16'h0030 || gcd2 !== 16'h0012 || parserIdle !== 1'b1) begin
            errors++;
            $display("[TB] FAIL chk_hold actual=%h/%h idle%b required=0030/0012 idle1", gcd1, gcd2, parserIdle);
        end
        tick();
        checks++;
        if (frameError !== 1'b0 || errorCode !== 2'd1) begin
            errors++;
            $display("[TB] FAIL chk_pulse_hold actual=err%b code%0d required=err0 code1", frameError, errorCode);
        end
    endtask

    task automatic test_zero_operand();
        sendByte(8'h11);
        sendByte(8'h22);
        tick();
        checks++;
        if (frameError !== 1'b0 || parserIdle !== 1'b1) begin
            errors++;
            $display("[TB] FAIL garbage_ignored actual=err%b idle%b required=err0 idle1", frameError, parserIdle);
        end
        sendFrame(8'hA5, 8'h00, 8'h00, 8'h00, 8'h07, 8'h07);
        tick();
        checks++;
        if (frameError !== 1'b1 || errorCode !== 2'd2 || startGcd !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_error actual=err%b code%0d start%b required=err1 code2 start0",
                     frameError, errorCode, startGcd);
        end
        checks++;
        if (acceptedCount !== 8'd1) begin
            errors++;
            $display("[TB] FAIL zero_count actual=%0d required=1", acceptedCount);
        end
    endtask

    task automatic test_busy_hold();
        engineBusy = 1'b1;
        sendFrame(8'hA5, 8'h01, 8'h00, 8'h00, 8'h40, 8'h41);
        tick();
        checks++;
        if (startGcd !== 1'b0 || frameError !== 1'b0 || parserIdle !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_pending actual=start%b err%b idle%b required=start0 err0 idle0",
                     startGcd, frameError, parserIdle);
        end
        sendByte(8'h55);
        checks++;
        if (frameError !== 1'b1 || errorCode !== 2'd0 || startGcd !== 1'b0 || parserIdle !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_overrun actual=err%b code%0d start%b idle%b required=err1 code0 start0 idle0",
                     frameError, errorCode, startGcd, parserIdle);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (startGcd !== 1'b0 || parserIdle !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_still_holding actual=start%b idle%b required=start0 idle0", startGcd, parserIdle);
        end
        engineBusy = 1'b0;
        tick();
        checks++;
        if (startGcd !== 1'b1 || gcd1 !== 16'h0100 || gcd2 !== 16'h0040) begin
            errors++;
            $display("[TB] FAIL busy_release actual=start%b %h/%h required=start1 0100/0040", startGcd, gcd1, gcd2);
        end
        checks++;
        if (acceptedCount !== 8'd2) begin
            errors++;
            $display("[TB] FAIL busy_count actual=%0d required=2", acceptedCount);
        end
        tick();
    endtask

    task automatic test_timeout();
        sendByte(8'hA5);
        sendByte(8'h00);
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (frameError !== 1'b0 || parserIdle !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_early actual=err%b idle%b required=err0 idle0", frameError, parserIdle);
        end
        tick();
        checks++;
        if (frameError !== 1'b1 || errorCode !== 2'd3 || parserIdle !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_fire actual=err%b code%0d idle%b required=err1 code3 idle1",
                     frameError, errorCode, parserIdle);
        end
        tick();
        sendByte(8'hA5);
        sendByte(8'h00);
        for (int i = 0; i < 14; i++) tick();
        sendByte(8'h0C);
        checks++;
        if (frameError !== 1'b0 || parserIdle !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_byte_wins actual=err%b idle%b required=err0 idle0", frameError, parserIdle);
        end
        sendByte(8'h00);
        sendByte(8'h08);
        sendByte(8'h04);
        tick();
        checks++;
        if (startGcd !== 1'b1 || gcd1 !== 16'h000C || gcd2 !== 16'h0008 || acceptedCount !== 8'd3) begin
            errors++;
            $display("[TB] FAIL timeout_late_frame actual=start%b %h/%h cnt%0d required=start1 000c/0008 cnt3",
                     startGcd, gcd1, gcd2, acceptedCount);
        end
        tick();
    endtask

    task automatic test_reset_midframe();
        sendByte(8'hA5);
        sendByte(8'h00);
        sendByte(8'h30);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (parserIdle !== 1'b1 || acceptedCount !== 8'd0 || gcd1 !== 16'h0) begin
            errors++;
            $display("[TB] FAIL midreset_state actual=idle%b cnt%0d gcd1=%h required=idle1 cnt0 gcd1=0000",
                     parserIdle, acceptedCount, gcd1);
        end
        sendFrame(8'hA5, 8'h00, 8'h05, 8'h00, 8'h0F, 8'h0A);
        tick();
        checks++;
        if (startGcd !== 1'b1 || gcd1 !== 16'h0005 || gcd2 !== 16'h000F || acceptedCount !== 8'd1) begin
            errors++;
            $display("[TB] FAIL midreset_second actual=start%b %h/%h cnt%0d required=start1 0005/000f cnt1",
                     startGcd, gcd1, gcd2, acceptedCount);
        end
        tick();
        // A command parked in PENDING must vanish on reset.
        engineBusy = 1'b1;
        sendFrame(8'hA5, 8'h00, 8'h09, 8'h00, 8'h06, 8'h0F);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        engineBusy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (startGcd !== 1'b0) begin
                errors++;
                $display("[TB] FAIL pending_reset_start cycle%0d actual=%b required=0", i, startGcd);
            end
            tick();
        end
        checks++;
        if (acceptedCount !== 8'd0 || gcd1 !== 16'h0) begin
            errors++;
            $display("[TB] FAIL pending_reset_state actual=cnt%0d gcd1=%h required=cnt0 gcd1=0000", acceptedCount, gcd1);
        end
    endtask

    task automatic test_count_wrap();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 255; i++) begin
            sendFrame(8'hA5, 8'h00, 8'h03, 8'h00, 8'h06, 8'h05);
            tick();
            if (startGcd === 1'b1) pulses++;
            tick();
        end
        checks++;
        if (acceptedCount !== 8'd255 || pulses != 255) begin
            errors++;
            $display("[TB] FAIL wrap_255 actual=cnt%0d pulses%0d required=cnt255 pulses255", acceptedCount, pulses);
        end
        sendFrame(8'hA5, 8'h00, 8'h03, 8'h00, 8'h06, 8'h05);
        tick();
        checks++;
        if (acceptedCount !== 8'd0 || startGcd !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_zero actual=cnt%0d start%b required=cnt0 start1", acceptedCount, startGcd);
        end
    endtask

    initial begin
        reset      = 1'b1;
        rxValid    = 1'b0;
        rxData     = 8'h00;
        engineBusy = 1'b0;
        #1;
        test_reset();
        test_valid_frame();
        test_bad_checksum();
        test_zero_operand();
        test_busy_hold();
        test_timeout();
        test_reset_midframe();
        test_count_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
